// File: rtl/ppu_oam_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ppu_oam_access_ctrl
// Brief    : Sprite OAM port arbiter (evaluation / $4014 DMA / $2003-$2004)
//            with OAMADDR ownership and the per-scanline evaluation kick.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_oam_access_ctrl #(
    parameter int DMA_LEN       = 256,
    parameter int DMA_ALIGN_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic        rendering,
    output logic        eval_start,
    input  logic        eval_busy,
    input  logic [7:0]  eval_addr,
    output logic [7:0]  oam_base,
    input  logic        oamaddr_wr,
    input  logic        oamdata_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  oamdata_out,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        cpu_halt,
    output logic        dma_rd_req,
    output logic [15:0] dma_rd_addr,
    input  logic        dma_rd_ack,
    input  logic [7:0]  dma_rd_data,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    input  logic [7:0]  oam_rdata
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ALIGN = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_WRITE = 2'd3;

    localparam logic [7:0] c_CNT_LAST   = 8'(DMA_LEN - 1);
    localparam logic [7:0] c_ALIGN_LAST = 8'(DMA_ALIGN_CYC - 1);

    logic [1:0] r_state;
    logic [7:0] r_page;
    logic [7:0] r_cnt;
    logic [7:0] r_align_cnt;
    logic [7:0] r_data;
    logic       r_cpu_halt;
    logic [7:0] r_oamaddr;
    logic       r_eval_start;
    logic       r_idle_q;
    logic [7:0] r_oamdata_out;

    logic w_eval_own;
    logic w_eval_trig;
    logic w_dma_wr;
    logic w_cpu_wr;
    logic w_idle;

    assign w_eval_own  = eval_busy | r_eval_start;
    assign w_eval_trig = line_start & rendering & ~eval_busy;
    // A scanline kick takes precedence over a pending DMA byte; that byte waits.
    assign w_dma_wr    = (r_state == c_ST_WRITE) & ~w_eval_own & ~w_eval_trig;
    assign w_cpu_wr    = oamdata_wr & ~oamaddr_wr & ~rendering & ~w_eval_own
                       & ~r_cpu_halt & ~w_dma_wr;
    assign w_idle      = ~w_eval_own & ~w_dma_wr & ~w_cpu_wr;

    always_comb begin
        oam_addr  = r_oamaddr;
        oam_wdata = 8'h00;
        oam_we    = 1'b0;
        if (w_eval_own) begin
            oam_addr = eval_addr;
        end else if (w_dma_wr) begin
            oam_addr  = r_oamaddr + r_cnt;
            oam_wdata = r_data;
            oam_we    = 1'b1;
        end else if (w_cpu_wr) begin
            oam_wdata = cpu_wdata;
            oam_we    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_page      <= 8'h00;
            r_cnt       <= 8'h00;
            r_align_cnt <= 8'h00;
            r_data      <= 8'h00;
            r_cpu_halt  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (dma_start) begin
                        r_page      <= dma_page;
                        r_cnt       <= 8'h00;
                        r_align_cnt <= 8'h00;
                        r_cpu_halt  <= 1'b1;
                        r_state     <= (DMA_ALIGN_CYC == 0) ? c_ST_READ : c_ST_ALIGN;
                    end
                end
                c_ST_ALIGN: begin
                    if (r_align_cnt == c_ALIGN_LAST) begin
                        r_state <= c_ST_READ;
                    end else begin
                        r_align_cnt <= r_align_cnt + 8'd1;
                    end
                end
                c_ST_READ: begin
                    if (dma_rd_ack) begin
                        r_data  <= dma_rd_data;
                        r_state <= c_ST_WRITE;
                    end
                end
                default: begin
                    if (w_dma_wr) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state    <= c_ST_IDLE;
                            r_cpu_halt <= 1'b0;
                        end else begin
                            r_state <= c_ST_READ;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oamaddr     <= 8'h00;
            r_eval_start  <= 1'b0;
            r_idle_q      <= 1'b0;
            r_oamdata_out <= 8'h00;
        end else begin
            if (oamaddr_wr) begin
                r_oamaddr <= cpu_wdata;
            end else if (w_cpu_wr) begin
                r_oamaddr <= r_oamaddr + 8'd1;
            end
            r_eval_start <= w_eval_trig;
            // RAM read data lags the address by one cycle.
            r_idle_q <= w_idle;
            if (r_idle_q) begin
                r_oamdata_out <= oam_rdata;
            end
        end
    end

    assign eval_start  = r_eval_start;
    assign oam_base    = r_oamaddr;
    assign oamdata_out = r_oamdata_out;
    assign cpu_halt    = r_cpu_halt;
    assign dma_rd_req  = (r_state == c_ST_READ);
    assign dma_rd_addr = dma_rd_req ? {r_page, r_cnt} : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_ppu_oam_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_oam_access_ctrl
// Brief    : Self-checking bench for ppu_oam_access_ctrl with OAM/bus models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_oam_access_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, line_start, rendering, eval_start, eval_busy;
    logic [7:0]  eval_addr, oam_base, cpu_wdata, oamdata_out, dma_page;
    logic        oamaddr_wr, oamdata_wr, dma_start, cpu_halt, dma_rd_req, dma_rd_ack;
    logic [15:0] dma_rd_addr;
    logic [7:0]  dma_rd_data, oam_addr, oam_wdata, oam_rdata;
    logic        oam_we;

    ppu_oam_access_ctrl #(.DMA_LEN(256), .DMA_ALIGN_CYC(1)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .rendering(rendering),
        .eval_start(eval_start), .eval_busy(eval_busy), .eval_addr(eval_addr),
        .oam_base(oam_base), .oamaddr_wr(oamaddr_wr), .oamdata_wr(oamdata_wr),
        .cpu_wdata(cpu_wdata), .oamdata_out(oamdata_out), .dma_start(dma_start),
        .dma_page(dma_page), .cpu_halt(cpu_halt), .dma_rd_req(dma_rd_req),
        .dma_rd_addr(dma_rd_addr), .dma_rd_ack(dma_rd_ack), .dma_rd_data(dma_rd_data),
        .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we), .oam_rdata(oam_rdata)
    );

    int checks = 0;
    int errors = 0;

    // OAM RAM: synchronous read, one cycle latency; self-initialising.
    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_ready <= 1'b1;
        end else if (oam_we) begin
            mem[oam_addr] <= oam_wdata;
        end
        oam_rdata <= mem[oam_addr];
    end

    // CPU bus responder: random latency, data = low address byte.
    logic [7:0] exp_page, exp_rd_idx;
    int ack_wait = 0, ack_cnt = 0, rd_bad = 0;
    always @(negedge clk) begin
        if (dma_rd_req && !dma_rd_ack) begin
            if (ack_wait == 0) begin
                dma_rd_ack  = 1'b1;
                dma_rd_data = dma_rd_addr[7:0];
                if (dma_rd_addr !== {exp_page, exp_rd_idx}) rd_bad++;
                exp_rd_idx++;
                ack_cnt++;
                ack_wait = $urandom_range(0, 2);
            end else begin
                ack_wait--;
            end
        end else begin
            dma_rd_ack = 1'b0;
        end
    end

    // Port monitor: count writes and eval pulses, flag writes under evaluation.
    int wr_cnt = 0, es_cnt = 0, viol = 0;
    always @(negedge clk) begin
        #1;
        if (oam_we) wr_cnt++;
        if (eval_start) es_cnt++;
        if ((eval_busy || eval_start) && (oam_we || oam_addr !== eval_addr)) viol++;
    end

    // Reference state: OAMADDR and expected RAM contents.
    logic [7:0] m_base;
    logic [7:0] exp_mem [256];
    logic       s_we;
    logic [7:0] s_addr, s_wdata, s_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_op(input logic aw, input logic dw, input logic rend, input logic [7:0] wd);
        @(negedge clk);
        oamaddr_wr = aw; oamdata_wr = dw; rendering = rend; cpu_wdata = wd;
        #1;
        s_we = oam_we; s_addr = oam_addr; s_wdata = oam_wdata;
        if (aw) m_base = wd;
        else if (dw && !rend) begin exp_mem[m_base] = wd; m_base++; end
        @(posedge clk); #1;
        oamaddr_wr = 1'b0; oamdata_wr = 1'b0; rendering = 1'b0;
        s_base = oam_base;
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic start_dma(input logic [7:0] page);
        exp_page = page; exp_rd_idx = 8'h00; ack_cnt = 0; wr_cnt = 0; rd_bad = 0;
        for (int i = 0; i < 256; i++) exp_mem[8'(m_base + 8'(i))] = 8'(i);
        @(negedge clk); dma_start = 1'b1; dma_page = page;
        @(negedge clk); dma_start = 1'b0;
        #1 check("halt_after_start", cpu_halt, 1);
    endtask

    task automatic wait_dma_done(input string tag);
        logic prev_we = 1'b0;
        bit   done = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk); #1;
            if (!cpu_halt) begin
                check({tag, "_halt_drop_after_last_wr"}, prev_we, 1);
                done = 1;
            end
            prev_we = oam_we;
        end
        if (!done) check({tag, "_dma_timeout"}, 0, 1);
        check({tag, "_reads"}, ack_cnt, 256);
        check({tag, "_read_addr_errs"}, rd_bad, 0);
        check({tag, "_writes"}, wr_cnt, 256);
        check({tag, "_mem_diffs"}, mem_diff(), 0);
        check({tag, "_base_kept"}, oam_base, m_base);
    endtask

    typedef struct {
        logic       aw, dw, rend;
        logic [7:0] wd;
        logic       exp_we;
        logic [7:0] exp_addr, exp_base;
        logic       chk_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        rst = 1'b1; line_start = 0; rendering = 0; eval_busy = 0; eval_addr = 0;
        oamaddr_wr = 0; oamdata_wr = 0; cpu_wdata = 0; dma_start = 0; dma_page = 0;
        dma_rd_ack = 0; dma_rd_data = 0; exp_page = 0; exp_rd_idx = 0; m_base = 0;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;

        vecs[0] = '{1, 0, 0, 8'h10, 0, 8'h00, 8'h10, 0};
        vecs[1] = '{0, 1, 0, 8'hAA, 1, 8'h10, 8'h11, 0};
        vecs[2] = '{0, 1, 0, 8'hBB, 1, 8'h11, 8'h12, 1};
        vecs[3] = '{0, 1, 1, 8'hCC, 0, 8'h12, 8'h12, 0};
        vecs[4] = '{1, 1, 0, 8'h40, 0, 8'h12, 8'h40, 0};
        vecs[5] = '{0, 0, 0, 8'h00, 0, 8'h40, 8'h40, 0};
        vecs[6] = '{0, 1, 0, 8'h55, 1, 8'h40, 8'h41, 0};
        vecs[7] = '{1, 0, 0, 8'hFF, 0, 8'h41, 8'hFF, 0};
        vecs[8] = '{0, 1, 0, 8'h66, 1, 8'hFF, 8'h00, 1};

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_eval_start", eval_start, 0);
        check("rst_cpu_halt", cpu_halt, 0);
        check("rst_rd_req", {dma_rd_req, dma_rd_addr}, 0);
        check("rst_oam_port", {oam_we, oam_addr, oam_wdata}, 0);
        check("rst_base", oam_base, 0);
        check("rst_oamdata_out", oamdata_out, 0);
        @(negedge clk); rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            cpu_op(vecs[k].aw, vecs[k].dw, vecs[k].rend, vecs[k].wd);
            check($sformatf("vec%0d_we", k), s_we, vecs[k].exp_we);
            check($sformatf("vec%0d_addr", k), s_addr, vecs[k].exp_addr);
            if (vecs[k].exp_we) check($sformatf("vec%0d_wdata", k), s_wdata, vecs[k].wd);
            check($sformatf("vec%0d_base", k), s_base, vecs[k].exp_base);
            if (vecs[k].chk_rd) begin
                repeat (2) @(posedge clk); #1;
                check($sformatf("vec%0d_oamdata_out", k), oamdata_out, exp_mem[m_base]);
            end
        end
        cpu_op(1, 0, 0, 8'h11);
        repeat (2) @(posedge clk); #1;
        check("readback_0x11", oamdata_out, 8'hBB);

        for (int k = 0; k < 60; k++) begin
            logic aw, dw, rend;
            aw = ($urandom_range(0, 3) == 0); dw = $urandom_range(0, 1) == 1;
            rend = ($urandom_range(0, 3) == 0);
            cpu_op(aw, dw, rend, 8'($urandom));
            check("rand_we", s_we, dw && !aw && !rend);
            check("rand_base", s_base, m_base);
        end
        for (int k = 0; k < 4; k++) begin
            logic [7:0] a;
            a = 8'($urandom);
            cpu_op(1, 0, 0, a);
            repeat (2) @(posedge clk); #1;
            check("rand_readback", oamdata_out, exp_mem[a]);
        end

        // DMA with OAMADDR wrap.
        cpu_op(1, 0, 0, 8'hFC);
        start_dma(8'h02);
        wait_dma_done("dma_wrap");

        // DMA interrupted by a scanline evaluation.
        cpu_op(1, 0, 0, 8'h30);
        viol = 0;
        start_dma(8'h07);
        repeat (40) @(negedge clk);
        es_cnt = 0;
        line_start = 1'b1; rendering = 1'b1;
        @(negedge clk);
        line_start = 1'b0; eval_busy = 1'b1; eval_addr = 8'($urandom);
        #1 check("eval_start_pulse", eval_start, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            eval_addr = 8'($urandom);
            line_start = (k == 5);
        end
        @(negedge clk);
        eval_busy = 1'b0; rendering = 1'b0; line_start = 1'b0;
        wait_dma_done("dma_eval");
        check("eval_start_count", es_cnt, 1);
        check("eval_port_violations", viol, 0);

        // Asynchronous reset in the middle of a DMA, then a fresh full transfer.
        start_dma(8'h09);
        for (int c = 0; c < 3000 && ack_cnt < 100; c++) @(negedge clk);
        check("reached_byte_100", ack_cnt >= 100, 1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_halt", cpu_halt, 0);
        check("async_rst_rd_req", dma_rd_req, 0);
        check("async_rst_base", oam_base, 0);
        @(posedge clk); @(negedge clk); rst = 1'b0;
        m_base = 8'h00;
        start_dma(8'h05);
        wait_dma_done("dma_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
